// File: rtl/pwm_ramp_profile.sv
// rtl/pwm_ramp_profile.sv - PWM duty ramp generator stepping from start duty to target duty, then holding.
module pwm_ramp_profile #(
    parameter int PERIOD       = 100,
    parameter int STEP_PERIODS = 3333,
    parameter int DUTY_W       = 7
) (
    input  logic              clk_1mhz,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [DUTY_W-1:0] start_duty,
    input  logic [DUTY_W-1:0] end_duty,
    input  logic [DUTY_W-1:0] duty_step,
    output logic              pwm_signal,
    output logic [DUTY_W-1:0] cur_duty,
    output logic              active,
    output logic              done,
    output logic              aborted
);

    localparam int SCNT_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [DUTY_W-1:0] PERIOD_D  = DUTY_W'(PERIOD);
    localparam logic [DUTY_W-1:0] PCNT_LAST = DUTY_W'(PERIOD - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STEP_PERIODS - 1);

    typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;

    state_t            state, state_n;
    logic              start_prev;
    logic [DUTY_W-1:0] pcnt, pcnt_n;
    logic [SCNT_W-1:0] scnt, scnt_n;
    logic [DUTY_W-1:0] end_r, end_n;
    logic [DUTY_W-1:0] step_r, step_n;
    logic              dir_up, dir_up_n;
    logic              pwm_n;
    logic [DUTY_W-1:0] cur_n;
    logic              active_n, done_n, aborted_n;

    logic              start_edge;
    logic              do_load;
    logic [DUTY_W-1:0] s_start, s_end, s_step_c, s_step;
    logic [DUTY_W:0]   up_sum, dn_lim;
    logic [DUTY_W-1:0] stepped;
    logic [DUTY_W-1:0] pcnt_inc;

    assign start_edge = start & ~start_prev;

    // Sampled inputs are clamped to PERIOD; a zero step would stall the ramp, so it becomes 1.
    assign s_start  = (start_duty > PERIOD_D) ? PERIOD_D : start_duty;
    assign s_end    = (end_duty > PERIOD_D) ? PERIOD_D : end_duty;
    assign s_step_c = (duty_step > PERIOD_D) ? PERIOD_D : duty_step;
    assign s_step   = (s_step_c == '0) ? DUTY_W'(1) : s_step_c;

    // One extra bit keeps the step arithmetic free of wrap-around in both directions.
    assign up_sum  = {1'b0, cur_duty} + {1'b0, step_r};
    assign dn_lim  = {1'b0, end_r} + {1'b0, step_r};
    assign stepped = dir_up ? ((up_sum > {1'b0, end_r}) ? end_r : up_sum[DUTY_W-1:0])
                            : (({1'b0, cur_duty} >= dn_lim) ? (cur_duty - step_r) : end_r);

    assign pcnt_inc = (pcnt == PCNT_LAST) ? '0 : pcnt + DUTY_W'(1);

    always_ff @(posedge clk_1mhz) begin
        if (reset) begin
            state      <= IDLE;
            start_prev <= 1'b0;
            pcnt       <= '0;
            scnt       <= '0;
            end_r      <= '0;
            step_r     <= '0;
            dir_up     <= 1'b0;
            pwm_signal <= 1'b0;
            cur_duty   <= '0;
            active     <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            state      <= state_n;
            start_prev <= start;
            pcnt       <= pcnt_n;
            scnt       <= scnt_n;
            end_r      <= end_n;
            step_r     <= step_n;
            dir_up     <= dir_up_n;
            pwm_signal <= pwm_n;
            cur_duty   <= cur_n;
            active     <= active_n;
            done       <= done_n;
            aborted    <= aborted_n;
        end
    end

    always_comb begin
        state_n   = state;
        pcnt_n    = pcnt;
        scnt_n    = scnt;
        end_n     = end_r;
        step_n    = step_r;
        dir_up_n  = dir_up;
        pwm_n     = 1'b0;
        cur_n     = cur_duty;
        active_n  = active;
        done_n    = done;
        aborted_n = aborted;
        do_load   = 1'b0;

        case (state)
            IDLE: begin
                if (start_edge && !abort) begin
                    do_load = 1'b1;
                end
            end
            RAMP: begin
                if (abort) begin
                    state_n   = IDLE;
                    pcnt_n    = '0;
                    scnt_n    = '0;
                    cur_n     = '0;
                    active_n  = 1'b0;
                    aborted_n = 1'b1;
                end else begin
                    pwm_n  = (pcnt < cur_duty);
                    pcnt_n = pcnt_inc;
                    if (pcnt == PCNT_LAST) begin
                        if (scnt == SCNT_LAST) begin
                            scnt_n = '0;
                            cur_n  = stepped;
                            if (stepped == end_r) begin
                                state_n  = HOLD;
                                active_n = 1'b0;
                                done_n   = 1'b1;
                            end
                        end else begin
                            scnt_n = scnt + SCNT_W'(1);
                        end
                    end
                end
            end
            HOLD: begin
                pwm_n  = (pcnt < cur_duty);
                pcnt_n = pcnt_inc;
                if (start_edge && !abort) begin
                    do_load = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (do_load) begin
            cur_n     = s_start;
            end_n     = s_end;
            step_n    = s_step;
            dir_up_n  = (s_end > s_start);
            pcnt_n    = '0;
            scnt_n    = '0;
            aborted_n = 1'b0;
            if (s_start == s_end) begin
                state_n  = HOLD;
                active_n = 1'b0;
                done_n   = 1'b1;
            end else begin
                state_n  = RAMP;
                active_n = 1'b1;
                done_n   = 1'b0;
            end
        end
    end

endmodule
